// File: rtl/cpu_isa_pkg.sv
// ============================================================================
// Module : cpu_isa_pkg
// Brief  : ISA field encodings, condition codes, flag indices, controller
//          state enum and PC source encodings shared by the CPU control logic.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_isa_pkg;

    localparam logic [3:0] OPC_RTYPE   = 4'b0000;
    localparam logic [3:0] OPC_ADDI    = 4'b0001;
    localparam logic [3:0] OPC_LDST    = 4'b0100;
    localparam logic [3:0] OPC_BRANCH  = 4'b1100;
    localparam logic [3:0] OPC_ZEXT_A  = 4'b0110;
    localparam logic [3:0] OPC_ZEXT_B  = 4'b1000;

    localparam logic [3:0] EXT_LOAD    = 4'b0000;
    localparam logic [3:0] EXT_STORE   = 4'b0100;
    localparam logic [3:0] EXT_ZEXT    = 4'b0110;
    localparam logic [3:0] EXT_JUMP    = 4'b1100;

    localparam logic [3:0] ALU_OP_CMP  = 4'b1011;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_OVF    = 4'd1;
    localparam logic [3:0] COND_GT     = 4'd2;
    localparam logic [3:0] COND_EQ     = 4'd3;
    localparam logic [3:0] COND_START  = 4'd4;

    localparam int FLAG_OVF = 0;
    localparam int FLAG_GT  = 1;
    localparam int FLAG_EQ  = 3;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
    } ctrl_state_t;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_REL = 2'b01;
    localparam logic [1:0] PC_SRC_REG = 2'b10;

    function automatic logic is_itype(input logic [3:0] opc);
        case (opc)
            OPC_ADDI, 4'b0010, 4'b0011, 4'b0101,
            4'b0110, 4'b1001, 4'b1011, 4'b1110: is_itype = 1'b1;
            default:                            is_itype = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ============================================================================
// Module : branch_cond_eval
// Brief  : Combinational branch/jump condition evaluation from cond field,
//          registered ALU flags and the start input.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond_eval
    import cpu_isa_pkg::*;
#(
    parameter int FLAG_W = 5
) (
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    input  logic              start,
    output logic              taken
);

    // Flag bits with no associated condition code are intentionally ignored.
    logic w_unused_flags;
    assign w_unused_flags = ^flags;

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_OVF:    taken = flags[FLAG_OVF];
            COND_GT:     taken = flags[FLAG_GT];
            COND_EQ:     taken = flags[FLAG_EQ];
            COND_START:  taken = start;
            default:     taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module : multicycle_controller
// Brief  : FETCH/DECODE/EXECUTE/MEM/WB control sequencer with req/ack memory
//          handshake, instruction register and datapath strobes.
//          CTRL_START_SYNC_EN: 2-flop synchroniser on start_button.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import cpu_isa_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 15,
    parameter int FLAG_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               mem_ack,
    input  logic [FLAG_W-1:0]  flags,
    input  logic               start_button,
    output logic [INSTR_W-1:0] ir,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               ir_load,
    output logic [3:0]         op,
    output logic               select_immediate,
    output logic [INSTR_W-9:0] immediate_extend,
    output logic               reg_write,
    output logic               flag_write,
    output logic               wb_sel,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic [PC_W-1:0]    pc_offset,
    output logic [2:0]         state_dbg
);

    ctrl_state_t        r_state;
    ctrl_state_t        w_next_state;
    logic [INSTR_W-1:0] r_ir;
    logic               w_start;
    logic               w_taken;

    logic [3:0] w_opc;
    logic [3:0] w_cond;
    logic [3:0] w_ext;
    logic       w_is_rtype;
    logic       w_is_itype;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_imm_zext;
    logic [3:0] w_alu_op;

`ifdef CTRL_START_SYNC_EN
    logic [1:0] r_start_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_sync <= 2'b00;
        end else begin
            r_start_sync <= {r_start_sync[0], start_button};
        end
    end

    assign w_start = r_start_sync[1];
`else
    assign w_start = start_button;
`endif

    assign w_opc       = r_ir[15:12];
    assign w_cond      = r_ir[11:8];
    assign w_ext       = r_ir[7:4];
    assign w_is_rtype  = (w_opc == OPC_RTYPE);
    assign w_is_itype  = is_itype(w_opc);
    assign w_is_branch = (w_opc == OPC_BRANCH);
    assign w_is_jump   = (w_opc == OPC_LDST) && (w_ext == EXT_JUMP);
    assign w_is_load   = (w_opc == OPC_LDST) && (w_ext == EXT_LOAD);
    assign w_is_store  = (w_opc == OPC_LDST) && (w_ext == EXT_STORE);
    assign w_imm_zext  = (w_opc == OPC_ZEXT_A) || (w_opc == OPC_ZEXT_B) || (w_ext == EXT_ZEXT);
    assign w_alu_op    = w_is_rtype ? w_ext : w_opc;

    branch_cond_eval #(
        .FLAG_W (FLAG_W)
    ) u_cond (
        .cond  (w_cond),
        .flags (flags),
        .start (w_start),
        .taken (w_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (ir_load) begin
                r_ir <= instr_in;
            end
        end
    end

    // Reset masks every strobe so an in-flight request is withdrawn at once.
    always_comb begin
        w_next_state     = r_state;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr_sel     = 1'b0;
        ir_load          = 1'b0;
        op               = 4'd0;
        select_immediate = 1'b0;
        immediate_extend = '0;
        reg_write        = 1'b0;
        flag_write       = 1'b0;
        wb_sel           = 1'b0;
        pc_en            = 1'b0;
        pc_src           = PC_SRC_INC;
        pc_offset        = '0;
        if (!reset) begin
            immediate_extend = w_imm_zext ? '0 : {(INSTR_W-8){r_ir[7]}};
            case (r_state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_load      = 1'b1;
                        w_next_state = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    w_next_state = ST_FETCH;
                    if (w_is_branch) begin
                        pc_en = 1'b1;
                        if (w_taken) begin
                            pc_src    = PC_SRC_REL;
                            pc_offset = {{(PC_W-8){r_ir[7]}}, r_ir[7:0]};
                        end
                    end else if (w_is_jump) begin
                        pc_en  = 1'b1;
                        pc_src = w_taken ? PC_SRC_REG : PC_SRC_INC;
                    end else if (w_is_load || w_is_store) begin
                        w_next_state = ST_MEM;
                    end else if (w_is_rtype || w_is_itype) begin
                        w_next_state = ST_EXECUTE;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    op               = w_alu_op;
                    select_immediate = !w_is_rtype;
                    flag_write       = 1'b1;
                    reg_write        = (w_alu_op != ALU_OP_CMP);
                    pc_en            = 1'b1;
                    w_next_state     = ST_FETCH;
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = w_is_store;
                    if (mem_ack) begin
                        if (w_is_load) begin
                            w_next_state = ST_WB;
                        end else begin
                            pc_en        = 1'b1;
                            w_next_state = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    reg_write    = 1'b1;
                    wb_sel       = 1'b1;
                    pc_en        = 1'b1;
                    w_next_state = ST_FETCH;
                end
                default: w_next_state = ST_FETCH;
            endcase
        end
    end

    assign ir        = r_ir;
    assign state_dbg = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module : tb_multicycle_controller
// Brief  : Self-checking bench for multicycle_controller with an
//          instruction-level expectation model and randomized programs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    localparam int K_ALU = 0, K_BR = 1, K_JMP = 2, K_LD = 3, K_ST = 4, K_NOP = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr_in = '0;
    logic        mem_ack = 1'b0;
    logic [4:0]  flags = '0;
    logic        start_button = 1'b0;

    logic [15:0] ir;
    logic        mem_req, mem_we, mem_addr_sel, ir_load;
    logic [3:0]  op;
    logic        select_immediate;
    logic [7:0]  immediate_extend;
    logic        reg_write, flag_write, wb_sel, pc_en;
    logic [1:0]  pc_src;
    logic [14:0] pc_offset;
    logic [2:0]  state_dbg;

    multicycle_controller dut (
        .clk              (clk),
        .reset            (reset),
        .instr_in         (instr_in),
        .mem_ack          (mem_ack),
        .flags            (flags),
        .start_button     (start_button),
        .ir               (ir),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr_sel     (mem_addr_sel),
        .ir_load          (ir_load),
        .op               (op),
        .select_immediate (select_immediate),
        .immediate_extend (immediate_extend),
        .reg_write        (reg_write),
        .flag_write       (flag_write),
        .wb_sel           (wb_sel),
        .pc_en            (pc_en),
        .pc_src           (pc_src),
        .pc_offset        (pc_offset),
        .state_dbg        (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        req, we, asel, irl, rw, fw, wbs, pcen;
        logic [1:0]  src;
        logic        chk_alu;
        logic [3:0]  op;
        logic        seli;
        logic [7:0]  iext;
        logic        chk_off;
        logic [14:0] off;
        logic        chk_ir;
        logic [15:0] irv;
    } exp_t;

    exp_t        exp_c = '0;
    logic        exp_valid = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic        start_d1 = 1'b0, start_d2 = 1'b0;
    logic [15:0] cur_ir = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", name, act, want, $time);
        end
    endtask

    // Instruction-level model of the decoded behaviour
    function automatic int kind_of(input logic [15:0] x);
        logic [3:0] o, e;
        o = x[15:12];
        e = x[7:4];
        if (o == 4'hC) return K_BR;
        if (o == 4'h4) begin
            if (e == 4'hC) return K_JMP;
            if (e == 4'h0) return K_LD;
            if (e == 4'h4) return K_ST;
            return K_NOP;
        end
        if (o inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hE}) return K_ALU;
        return K_NOP;
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] f, input logic s);
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return f[0];
            4'd2:    return f[1];
            4'd3:    return f[3];
            4'd4:    return s;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [14:0] model_off(input logic [7:0] imm);
        int d;
        d = imm[7] ? int'(imm) - 256 : int'(imm);
        return 15'(d);
    endfunction

    function automatic logic [7:0] model_iext(input logic [15:0] x);
        if (x[15:12] == 4'h6 || x[15:12] == 4'h8 || x[7:4] == 4'h6) return 8'h00;
        return x[7] ? 8'hFF : 8'h00;
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        e.chk_ir = 1'b1;
        e.irv = cur_ir;
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            cmp("state_dbg",    32'(state_dbg),    32'(exp_c.st));
            cmp("mem_req",      32'(mem_req),      32'(exp_c.req));
            cmp("mem_we",       32'(mem_we),       32'(exp_c.we));
            cmp("mem_addr_sel", 32'(mem_addr_sel), 32'(exp_c.asel));
            cmp("ir_load",      32'(ir_load),      32'(exp_c.irl));
            cmp("reg_write",    32'(reg_write),    32'(exp_c.rw));
            cmp("flag_write",   32'(flag_write),   32'(exp_c.fw));
            cmp("wb_sel",       32'(wb_sel),       32'(exp_c.wbs));
            cmp("pc_en",        32'(pc_en),        32'(exp_c.pcen));
            cmp("pc_src",       32'(pc_src),       32'(exp_c.src));
            if (exp_c.chk_alu) begin
                cmp("op",               32'(op),               32'(exp_c.op));
                cmp("select_immediate", 32'(select_immediate), 32'(exp_c.seli));
                cmp("immediate_extend", 32'(immediate_extend), 32'(exp_c.iext));
            end
            if (exp_c.chk_off) cmp("pc_offset", 32'(pc_offset), 32'(exp_c.off));
            if (exp_c.chk_ir)  cmp("ir", 32'(ir), 32'(exp_c.irv));
        end
    end

    task automatic do_cycle(input exp_t e, input logic ack);
        mem_ack   = ack;
        exp_c     = e;
        exp_valid = 1'b1;
        @(posedge clk);
        if (reset) begin
            start_d1 = 1'b0;
            start_d2 = 1'b0;
        end else begin
            start_d2 = start_d1;
            start_d1 = start_button;
        end
        #1;
    endtask

    task automatic run_instr(input logic [15:0] x, input int fwait, input int mwait,
                             input logic [4:0] fl, input logic st);
        exp_t       e;
        int         k;
        logic       s_eff, tk;
        logic [3:0] op_e;
        flags = fl;
        start_button = st;
        for (int i = 0; i < fwait; i++) begin
            instr_in = 16'($urandom);
            e = base(3'd0);
            e.req = 1'b1;
            do_cycle(e, 1'b0);
        end
        instr_in = x;
        e = base(3'd0);
        e.req = 1'b1;
        e.irl = 1'b1;
        do_cycle(e, 1'b1);
        cur_ir = x;
        instr_in = 16'($urandom);
        k = kind_of(x);
`ifdef CTRL_START_SYNC_EN
        s_eff = start_d2;
`else
        s_eff = start_button;
`endif
        tk = cond_ok(x[11:8], fl, s_eff);
        e = base(3'd1);
        case (k)
            K_BR: begin
                e.pcen = 1'b1;
                if (tk) begin
                    e.src = 2'b01;
                    e.chk_off = 1'b1;
                    e.off = model_off(x[7:0]);
                end
            end
            K_JMP:   begin e.pcen = 1'b1; e.src = tk ? 2'b10 : 2'b00; end
            K_NOP:   e.pcen = 1'b1;
            default: ;
        endcase
        do_cycle(e, 1'($urandom));
        if (k == K_ALU) begin
            op_e = (x[15:12] == 4'h0) ? x[7:4] : x[15:12];
            e = base(3'd2);
            e.chk_alu = 1'b1;
            e.op = op_e;
            e.seli = (x[15:12] != 4'h0);
            e.iext = model_iext(x);
            e.fw = 1'b1;
            e.rw = (op_e != 4'hB);
            e.pcen = 1'b1;
            do_cycle(e, 1'($urandom));
        end
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i <= mwait; i++) begin
                e = base(3'd3);
                e.req = 1'b1;
                e.asel = 1'b1;
                e.we = (k == K_ST);
                e.pcen = (i == mwait) && (k == K_ST);
                do_cycle(e, i == mwait);
            end
            if (k == K_LD) begin
                e = base(3'd4);
                e.rw = 1'b1;
                e.wbs = 1'b1;
                e.pcen = 1'b1;
                do_cycle(e, 1'($urandom));
            end
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom_range(0, 5))
            0: begin x[15:12] = 4'hC; x[11:8] = 4'($urandom_range(0, 6)); end
            1: begin x[15:12] = 4'h4; x[7:4] = 4'hC; x[11:8] = 4'($urandom_range(0, 6)); end
            2: begin x[15:12] = 4'h4; x[7:4] = 4'h0; end
            3: begin x[15:12] = 4'h4; x[7:4] = 4'h4; end
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        exp_t e;
        // Hand-computed anchors for the model itself
        cmp("pin_kind_alu",  32'(kind_of(16'h5183)), 32'(K_ALU));
        cmp("pin_kind_br",   32'(kind_of(16'hC3FE)), 32'(K_BR));
        cmp("pin_kind_jmp",  32'(kind_of(16'h44C0)), 32'(K_JMP));
        cmp("pin_kind_ld",   32'(kind_of(16'h4102)), 32'(K_LD));
        cmp("pin_kind_st",   32'(kind_of(16'h4140)), 32'(K_ST));
        cmp("pin_kind_nop",  32'(kind_of(16'h4180)), 32'(K_NOP));
        cmp("pin_off",       32'(model_off(8'hFE)),  32'h7FFE);
        cmp("pin_iext_sx",   32'(model_iext(16'h5183)), 32'hFF);
        cmp("pin_iext_zx",   32'(model_iext(16'h6183)), 32'h00);
        cmp("pin_cond_eq",   32'(cond_ok(4'd3, 5'b01000, 1'b0)), 32'd1);
        cmp("pin_cond_never",32'(cond_ok(4'd5, 5'b11111, 1'b1)), 32'd0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e = base(3'd0);
            do_cycle(e, 1'($urandom));
        end
        reset = 1'b0;

        run_instr(16'h5183, 3, 0, 5'b00000, 1'b0);
        run_instr(16'hC3FE, 0, 0, 5'b01000, 1'b0);
        run_instr(16'hC3FE, 0, 0, 5'b10111, 1'b0);
        run_instr(16'h4102, 1, 1, 5'b00000, 1'b0);
        run_instr(16'h4140, 0, 2, 5'b00000, 1'b0);
        run_instr(16'h44C0, 2, 0, 5'b00000, 1'b1);
        run_instr(16'h44C0, 2, 0, 5'b00000, 1'b0);
        run_instr(16'h0B30, 0, 0, 5'b00000, 1'b0);

        // Reset while MEM waits on an acknowledge
        flags = '0;
        start_button = 1'b0;
        instr_in = 16'h4102;
        e = base(3'd0); e.req = 1'b1; e.irl = 1'b1;
        do_cycle(e, 1'b1);
        cur_ir = 16'h4102;
        e = base(3'd1);
        do_cycle(e, 1'b0);
        e = base(3'd3); e.req = 1'b1; e.asel = 1'b1;
        do_cycle(e, 1'b0);
        reset = 1'b1;
        e = base(3'd3);
        do_cycle(e, 1'b1);
        reset = 1'b0;
        cur_ir = '0;
        e = base(3'd0); e.req = 1'b1;
        do_cycle(e, 1'b0);

        for (int n = 0; n < 300; n++) begin
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                      5'($urandom), 1'($urandom));
        end

        exp_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
